// File: rtl/cmd_loader.sv
// TRS-80 /CMD image parser: turns streamed load records into handshaked memory
// writes, skips comment records and reports the transfer address of the image.
module cmd_loader #(
    parameter logic [7:0] CMD_INDEX = 8'd2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic        loader_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic [15:0] exec_addr,
    output logic        exec_valid,
    output logic        error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TYPE,
        S_LEN,
        S_ADLO,
        S_ADHI,
        S_DATA,
        S_WRITE,
        S_SKIP,
        S_XLO,
        S_XHI,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  type_reg, type_next;
    logic [8:0]  cnt_reg, cnt_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [7:0]  mem_data_reg, mem_data_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        ioctl_wait_reg, ioctl_wait_next;
    logic        loader_en_reg, loader_en_next;
    logic [15:0] exec_addr_reg, exec_addr_next;
    logic        exec_valid_reg, exec_valid_next;
    logic        error_reg, error_next;
    logic        dl_prev_reg;
    logic        end_pending_reg, end_pending_next;

    logic dl_rise;
    logic dl_fall;
    logic end_now;

    assign dl_rise = ioctl_download & ~dl_prev_reg;
    assign dl_fall = ~ioctl_download & dl_prev_reg;

    assign ioctl_wait = ioctl_wait_reg;
    assign loader_en  = loader_en_reg;
    assign mem_wr     = mem_wr_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_data   = mem_data_reg;
    assign exec_addr  = exec_addr_reg;
    assign exec_valid = exec_valid_reg;
    assign error      = error_reg;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            type_reg        <= 8'd0;
            cnt_reg         <= 9'd0;
            mem_addr_reg    <= 16'd0;
            mem_data_reg    <= 8'd0;
            mem_wr_reg      <= 1'b0;
            ioctl_wait_reg  <= 1'b0;
            loader_en_reg   <= 1'b0;
            exec_addr_reg   <= 16'd0;
            exec_valid_reg  <= 1'b0;
            error_reg       <= 1'b0;
            dl_prev_reg     <= 1'b0;
            end_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            type_reg        <= type_next;
            cnt_reg         <= cnt_next;
            mem_addr_reg    <= mem_addr_next;
            mem_data_reg    <= mem_data_next;
            mem_wr_reg      <= mem_wr_next;
            ioctl_wait_reg  <= ioctl_wait_next;
            loader_en_reg   <= loader_en_next;
            exec_addr_reg   <= exec_addr_next;
            exec_valid_reg  <= exec_valid_next;
            error_reg       <= error_next;
            dl_prev_reg     <= ioctl_download;
            end_pending_reg <= end_pending_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        type_next        = type_reg;
        cnt_next         = cnt_reg;
        mem_addr_next    = mem_addr_reg;
        mem_data_next    = mem_data_reg;
        mem_wr_next      = mem_wr_reg;
        ioctl_wait_next  = ioctl_wait_reg;
        loader_en_next   = loader_en_reg;
        exec_addr_next   = exec_addr_reg;
        exec_valid_next  = 1'b0;
        error_next       = error_reg;
        end_pending_next = end_pending_reg;

        case (state_reg)
            S_IDLE: begin
                if (dl_rise && ioctl_index == CMD_INDEX) begin
                    loader_en_next   = 1'b1;
                    error_next       = 1'b0;
                    exec_addr_next   = 16'd0;
                    end_pending_next = 1'b0;
                    state_next       = S_TYPE;
                end
            end
            S_TYPE: begin
                if (ioctl_wr) begin
                    type_next  = ioctl_data;
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (ioctl_wr) begin
                    if (type_reg == 8'h01) begin
                        // Length counts the two address bytes; 0..2 wrap past 256.
                        cnt_next   = (ioctl_data <= 8'd2) ? ({1'b1, ioctl_data} - 9'd2)
                                                          : ({1'b0, ioctl_data} - 9'd2);
                        state_next = S_ADLO;
                    end else if (type_reg == 8'h02) begin
                        state_next = S_XLO;
                    end else begin
                        cnt_next   = (ioctl_data == 8'd0) ? 9'd256 : {1'b0, ioctl_data};
                        state_next = S_SKIP;
                    end
                end
            end
            S_ADLO: begin
                if (ioctl_wr) begin
                    mem_addr_next[7:0] = ioctl_data;
                    state_next         = S_ADHI;
                end
            end
            S_ADHI: begin
                if (ioctl_wr) begin
                    mem_addr_next[15:8] = ioctl_data;
                    state_next          = S_DATA;
                end
            end
            S_DATA: begin
                if (ioctl_wr) begin
                    mem_data_next   = ioctl_data;
                    mem_wr_next     = 1'b1;
                    ioctl_wait_next = 1'b1;
                    state_next      = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    mem_wr_next     = 1'b0;
                    ioctl_wait_next = 1'b0;
                    mem_addr_next   = mem_addr_reg + 16'd1;
                    cnt_next        = cnt_reg - 9'd1;
                    state_next      = (cnt_reg == 9'd1) ? S_TYPE : S_DATA;
                end
            end
            S_SKIP: begin
                if (ioctl_wr) begin
                    cnt_next = cnt_reg - 9'd1;
                    if (cnt_reg == 9'd1) begin
                        state_next = S_TYPE;
                    end
                end
            end
            S_XLO: begin
                if (ioctl_wr) begin
                    exec_addr_next[7:0] = ioctl_data;
                    state_next          = S_XHI;
                end
            end
            S_XHI: begin
                if (ioctl_wr) begin
                    exec_addr_next[15:8] = ioctl_data;
                    exec_valid_next      = 1'b1;
                    state_next           = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // End of file is judged on the state reached after any coinciding byte;
        // a write in flight is completed first and judged by where it lands.
        end_now = (dl_fall && state_reg != S_IDLE) || end_pending_reg;
        if (end_now) begin
            if (state_next == S_WRITE) begin
                end_pending_next = 1'b1;
            end else begin
                if (state_next != S_TYPE && state_next != S_DONE) begin
                    error_next = 1'b1;
                end
                end_pending_next = 1'b0;
                loader_en_next   = 1'b0;
                state_next       = S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cmd_loader.sv
// Bench for cmd_loader: directed and random /CMD files checked against a
// record-level parse of the byte stream.
module tb_cmd_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_data = 8'd0;
    logic        ioctl_wait;
    logic        loader_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic [15:0] exec_addr;
    logic        exec_valid;
    logic        error;

    cmd_loader #(.CMD_INDEX(8'd2)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .loader_en      (loader_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ack        (mem_ack),
        .exec_addr      (exec_addr),
        .exec_valid     (exec_valid),
        .error          (error)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors = 0;
    int miscompares = 0;

    // Memory responder: acknowledges ack_delay cycles after the request appears.
    int ack_delay = 0;
    int wr_age = 0;
    int gap_max = 0;
    assign mem_ack = mem_wr && (wr_age > ack_delay);

    logic [23:0] got_w[$];
    int          exec_pulses = 0;
    int          exec_highs = 0;
    int          wait_run = 0;
    int          wait_runs[$];
    bit          loader_seen = 0;
    logic        prev_wr = 1'b0;
    logic        prev_ev = 1'b0;
    logic        prev_wait = 1'b0;

    always @(negedge clk_sys) begin
        if (mem_wr && !prev_wr) got_w.push_back({mem_addr, mem_data});
        if (exec_valid) exec_highs++;
        if (exec_valid && !prev_ev) exec_pulses++;
        if (ioctl_wait) wait_run++;
        else if (prev_wait) begin
            wait_runs.push_back(wait_run);
            wait_run = 0;
        end
        if (loader_en) loader_seen = 1;
        wr_age = mem_wr ? wr_age + 1 : 0;
        prev_wr   = mem_wr;
        prev_ev   = exec_valid;
        prev_wait = ioctl_wait;
    end

    logic [7:0]  file_b[$];
    logic [23:0] exp_w[$];
    logic [15:0] exp_exec;
    int          exp_ev;
    bit          exp_err;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference parse of file_b at record level.
    task automatic model();
        int pos;
        int n;
        int cnt;
        logic [7:0]  t;
        logic [7:0]  l;
        logic [15:0] a;
        bit stop;
        exp_w.delete();
        exp_exec = 16'd0;
        exp_ev = 0;
        exp_err = 0;
        n = file_b.size();
        pos = 0;
        stop = 0;
        while (!stop && pos < n) begin
            t = file_b[pos];
            pos++;
            if (pos >= n) begin exp_err = 1; break; end
            l = file_b[pos];
            pos++;
            if (t == 8'h01) begin
                cnt = (l <= 2) ? int'(l) + 254 : int'(l) - 2;
                if (pos + 2 > n) begin exp_err = 1; break; end
                a = {file_b[pos + 1], file_b[pos]};
                pos += 2;
                for (int k = 0; k < cnt; k++) begin
                    if (pos >= n) begin exp_err = 1; stop = 1; break; end
                    exp_w.push_back({a, file_b[pos]});
                    pos++;
                    a = a + 16'd1;
                end
            end else if (t == 8'h02) begin
                if (pos + 2 > n) begin exp_err = 1; break; end
                exp_exec = {file_b[pos + 1], file_b[pos]};
                exp_ev = 1;
                stop = 1;
            end else begin
                cnt = (l == 0) ? 256 : int'(l);
                if (pos + cnt > n) begin exp_err = 1; break; end
                pos += cnt;
            end
        end
    endtask

    task automatic start_capture();
        @(posedge clk_sys);
        got_w.delete();
        wait_runs.delete();
        exec_pulses = 0;
        exec_highs = 0;
        wait_run = 0;
        loader_seen = 0;
        @(negedge clk_sys);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (ioctl_wait && guard < 200) begin
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 200) chk($sformatf("%s wait_bound", tag), {31'd0, ioctl_wait}, 32'd0);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input bit drop_with);
        wait_ready(tag);
        ioctl_wr = 1'b1;
        ioctl_data = b;
        if (drop_with) ioctl_download = 1'b0;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk_sys);
    endtask

    task automatic run_file(input string name, input logic [7:0] idx, input bit drop_last, input int ack_d);
        bit sel;
        int guard;
        sel = (idx == 8'd2);
        ack_delay = ack_d;
        start_capture();
        ioctl_index = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk($sformatf("%s start_en", name), {31'd0, loader_en}, {31'd0, sel});
        if (sel) chk($sformatf("%s start_err", name), {31'd0, error}, 32'd0);
        for (int i = 0; i < file_b.size(); i++)
            send_byte(name, file_b[i], drop_last && (i == file_b.size() - 1));
        if (!drop_last) begin
            wait_ready(name);
            ioctl_download = 1'b0;
        end
        guard = 0;
        while ((loader_en || mem_wr) && guard < 100) begin
            @(negedge clk_sys);
            guard++;
        end
        repeat (3) @(negedge clk_sys);
        chk($sformatf("%s end_en", name), {31'd0, loader_en}, 32'd0);
        chk($sformatf("%s end_wr", name), {31'd0, mem_wr}, 32'd0);
        model();
        if (!sel) begin
            exp_w.delete();
            exp_ev = 0;
        end
        chk($sformatf("%s nwr", name), got_w.size(), exp_w.size());
        for (int k = 0; k < got_w.size() && k < exp_w.size(); k++)
            chk($sformatf("%s wr%0d", name, k), {8'd0, got_w[k]}, {8'd0, exp_w[k]});
        chk($sformatf("%s ev_pulses", name), exec_pulses, exp_ev);
        chk($sformatf("%s ev_width", name), exec_highs, exp_ev);
        chk($sformatf("%s seen_en", name), {31'd0, loader_seen}, {31'd0, sel});
        if (sel) begin
            chk($sformatf("%s exec", name), {16'd0, exec_addr}, {16'd0, exp_exec});
            chk($sformatf("%s err", name), {31'd0, error}, {31'd0, exp_err});
        end
        $display("file %s: %0d bytes, %0d writes, exec %04h, error %0d",
                 name, file_b.size(), got_w.size(), exec_addr, error);
    endtask

    task automatic load(input logic [7:0] bytes[$]);
        file_b = bytes;
    endtask

    initial begin
        logic [7:0] tmp[$];
        int nrec;
        int cnt;
        logic [7:0] l;

        // reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_outs", {26'd0, ioctl_wait, loader_en, mem_wr, exec_valid, error, 1'b0},
            32'd0);
        chk("rst_addr", {mem_data, mem_addr, 8'd0}, 32'd0);
        chk("rst_exec", {16'd0, exec_addr}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);

        // basic load + exec, last byte coincides with download fall
        tmp = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};
        load(tmp);
        run_file("basic", 8'd2, 1'b1, 0);
        chk("basic exec_const", {16'd0, exec_addr}, 32'h5200);

        // 256-byte record wrapping the address, then an exec record
        tmp = '{8'h01, 8'h02, 8'hC0, 8'hFF};
        for (int i = 0; i < 256; i++) tmp.push_back(8'($urandom));
        tmp.push_back(8'h02); tmp.push_back(8'h02); tmp.push_back(8'h34); tmp.push_back(8'h12);
        load(tmp);
        run_file("wrap", 8'd2, 1'b0, 0);
        if (got_w.size() == 256) begin
            chk("wrap first", {16'd0, got_w[0][23:8]}, 32'hFFC0);
            chk("wrap last", {16'd0, got_w[255][23:8]}, 32'h00BF);
        end

        // slow memory: wait held 6 cycles per byte
        tmp = '{8'h01, 8'h04, 8'h00, 8'h60, 8'h11, 8'h22};
        load(tmp);
        run_file("slow", 8'd2, 1'b0, 5);
        chk("slow nruns", wait_runs.size(), 2);
        for (int i = 0; i < wait_runs.size(); i++)
            chk($sformatf("slow run%0d", i), wait_runs[i], 6);

        // comment record skipped
        tmp = '{8'h05, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h03, 8'h00, 8'h70, 8'h99};
        load(tmp);
        run_file("comment", 8'd2, 1'b0, 1);

        // truncated record
        tmp = '{8'h01, 8'h07, 8'h00, 8'h80, 8'h11, 8'h22};
        load(tmp);
        run_file("trunc", 8'd2, 1'b0, 0);
        tmp = '{8'h01, 8'h03, 8'h10, 8'h80, 8'h5A};
        load(tmp);
        run_file("after_trunc", 8'd2, 1'b0, 0);

        // wrong slot is ignored
        tmp = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC};
        load(tmp);
        run_file("other_idx", 8'd1, 1'b0, 0);

        // random files
        for (int f = 0; f < 8; f++) begin
            tmp.delete();
            nrec = $urandom_range(1, 3);
            for (int r = 0; r < nrec; r++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tmp.push_back(8'($urandom_range(3, 255)));
                    l = 8'($urandom_range(0, 6));
                    tmp.push_back(l);
                    cnt = (l == 0) ? 256 : int'(l);
                end else begin
                    tmp.push_back(8'h01);
                    l = 8'($urandom_range(0, 14));
                    tmp.push_back(l);
                    tmp.push_back(8'($urandom));
                    tmp.push_back(8'($urandom));
                    cnt = (l <= 2) ? int'(l) + 254 : int'(l) - 2;
                end
                for (int k = 0; k < cnt; k++) tmp.push_back(8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                tmp.push_back(8'h02); tmp.push_back(8'h02);
                tmp.push_back(8'($urandom)); tmp.push_back(8'($urandom));
            end
            load(tmp);
            gap_max = $urandom_range(0, 2);
            run_file($sformatf("rand%0d", f), 8'd2, 1'b0, $urandom_range(0, 3));
        end
        gap_max = 0;

        // asynchronous reset while parked in DATA
        tmp = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA};
        ack_delay = 0;
        start_capture();
        ioctl_index = 8'd2;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < tmp.size(); i++) send_byte("rst_mid", tmp[i], 1'b0);
        wait_ready("rst_mid");
        chk("rst_mid pre_en", {31'd0, loader_en}, 32'd1);
        chk("rst_mid pre_addr", {16'd0, mem_addr}, 32'h5201);
        #2;
        reset = 1'b0;
        ioctl_download = 1'b0;
        #1;
        chk("rst_mid outs", {26'd0, ioctl_wait, loader_en, mem_wr, exec_valid, error, 1'b0},
            32'd0);
        chk("rst_mid addr", {mem_data, mem_addr, 8'd0}, 32'd0);
        chk("rst_mid exec", {16'd0, exec_addr}, 32'd0);
        $display("file rst_mid: reset applied in DATA, loader_en %0d", loader_en);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
